// File: rtl/fib_stream_checker.sv
// fib_stream_checker
//   Downstream monitor for a W-bit Fibonacci counter output stream.
//   Locks onto the stream after a 1,1 pair, then tracks it with a mirror
//   model of the generator. Every locked sample that deviates from the
//   model is flagged and counted. Model overflow/restart points (wraps)
//   are marked, and the number of matched samples between consecutive wraps
//   is reported as the wrap period.
//
// Parameters
//   W      data width of the monitored stream (W >= 3)
//   CNT_W  width of err_count and period_len
//
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous, active-high reset
//   in_valid     in   1      sample qualifier; in_data captured when 1
//   in_data      in   W      Fibonacci stream sample
//   locked       out  1      1 while the checker is tracking the stream
//   err_pulse    out  1      1-cycle pulse: locked sample mismatched the model
//   err_count    out  CNT_W  total mismatches since reset, saturating
//   wrap_pulse   out  1      1-cycle pulse: matched sample caused model restart
//   period_len   out  CNT_W  matched samples between the last two wraps,
//                            including the wrapping sample (saturating)
//   period_valid out  1      1-cycle pulse when period_len updates
//
// All outputs are registered: a sample captured on an edge is reflected on
// the outputs right after that edge. Cycles with in_valid=0 hold all state
// and drop the pulses.

module fib_stream_checker #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] period_len,
  output logic             period_valid
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SEEN1  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE_W = W'(1);
  localparam logic [W-1:0] TWO_W = W'(2);

  state_t           state;
  logic [W-1:0]     model_p;     // previous term of the mirror model
  logic [W-1:0]     model_c;     // current term = next expected sample
  logic [CNT_W-1:0] period_cnt;  // matched samples since the last wrap
  logic             wrap_seen;   // a wrap has occurred since the last lock

  // Saturating increment for counters that must never roll over.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next model term at W+1 bits; the carry bit marks generator overflow.
  function automatic logic [W:0] next_term(input logic [W-1:0] p,
                                           input logic [W-1:0] c);
    next_term = {1'b0, p} + {1'b0, c};
  endfunction

  logic [W:0]       sum;
  logic             is_one;
  logic             match;
  logic             wraps;
  logic [CNT_W-1:0] period_cnt_inc;

  always_comb begin
    sum            = next_term(model_p, model_c);
    is_one         = (in_data == ONE_W);
    match          = (in_data == model_c);
    wraps          = sum[W];
    period_cnt_inc = sat_inc(period_cnt);
  end

  // Capture stage: FSM, mirror model, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SEARCH;
      model_p      <= '0;
      model_c      <= '0;
      period_cnt   <= '0;
      wrap_seen    <= 1'b0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
      wrap_pulse   <= 1'b0;
      period_len   <= '0;
      period_valid <= 1'b0;
    end else begin
      err_pulse    <= 1'b0;
      wrap_pulse   <= 1'b0;
      period_valid <= 1'b0;
      if (in_valid) begin
        case (state)
          SEARCH: begin
            if (is_one) state <= SEEN1;
          end
          SEEN1: begin
            if (is_one) begin
              // Second consecutive 1: the generator is at (1,1), so the
              // next expected term is 2.
              state      <= LOCKED;
              locked     <= 1'b1;
              model_p    <= ONE_W;
              model_c    <= TWO_W;
              period_cnt <= '0;
              wrap_seen  <= 1'b0;
            end else begin
              state <= SEARCH;
            end
          end
          LOCKED: begin
            if (match) begin
              if (wraps) begin
                // Generator restarts at (0,1); the first wrap after lock
                // only arms the period measurement.
                model_p    <= '0;
                model_c    <= ONE_W;
                wrap_pulse <= 1'b1;
                if (wrap_seen) begin
                  period_len   <= period_cnt_inc;
                  period_valid <= 1'b1;
                end
                period_cnt <= '0;
                wrap_seen  <= 1'b1;
              end else begin
                model_p    <= model_c;
                model_c    <= sum[W-1:0];
                period_cnt <= period_cnt_inc;
              end
            end else begin
              // Mismatch drops lock; the offending sample is not reused
              // as the start of a new 1,1 pair.
              err_pulse <= 1'b1;
              err_count <= sat_inc(err_count);
              locked    <= 1'b0;
              state     <= SEARCH;
              wrap_seen <= 1'b0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fib_stream_checker.sv
module tb_fib_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;

  // Instance A: W=4, CNT_W=8
  logic       va = 1'b0;
  logic [3:0] da = '0;
  logic       lka, epa, wpa, pva;
  logic [7:0] eca, pla;
  // Instance B: W=4, CNT_W=2
  logic       vb = 1'b0;
  logic [3:0] db = '0;
  logic       lkb, epb, wpb, pvb;
  logic [1:0] ecb, plb;
  // Instance C: W=5, CNT_W=8
  logic       vc = 1'b0;
  logic [4:0] dc = '0;
  logic       lkc, epc, wpc, pvc;
  logic [7:0] ecc, plc;

  fib_stream_checker #(.W(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .in_valid(va), .in_data(da),
    .locked(lka), .err_pulse(epa), .err_count(eca), .wrap_pulse(wpa),
    .period_len(pla), .period_valid(pva));

  fib_stream_checker #(.W(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(vb), .in_data(db),
    .locked(lkb), .err_pulse(epb), .err_count(ecb), .wrap_pulse(wpb),
    .period_len(plb), .period_valid(pvb));

  fib_stream_checker #(.W(5), .CNT_W(8)) dut_c (
    .clk(clk), .reset(reset), .in_valid(vc), .in_data(dc),
    .locked(lkc), .err_pulse(epc), .err_count(ecc), .wrap_pulse(wpc),
    .period_len(plc), .period_valid(pvc));

  int checks = 0;
  int errors = 0;

  // Reference model: stream position is an index into the Fibonacci cycle
  // 1,1,2,3,... that the generator repeats for a given width.
  typedef struct {
    int st;    // 0 searching, 1 saw one 1, 2 tracking
    int idx;   // index of the next expected term
    int cnt;   // matched samples since last wrap
    int seen;  // wrap seen since lock
    int err;
    int lk, ep, wp, pv, plen;
  } mdl_t;

  mdl_t ma, mb, mc;

  function automatic int fib(input int i);
    int a = 1, b = 1, t;
    for (int k = 0; k < i; k++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  // Number of terms in one generator cycle: terms below 2^w, stopping
  // before the first term that would not fit.
  function automatic int cyc_len(input int w);
    int n = 0;
    while (fib(n) < (1 << w)) n++;
    return n;
  endfunction

  function automatic void mstep(inout mdl_t m, input bit v, input int d,
                                input int w, input int cw);
    int mx = (1 << cw) - 1;
    int L  = cyc_len(w);
    m.ep = 0; m.wp = 0; m.pv = 0;
    if (!v) return;
    case (m.st)
      0: if (d == 1) m.st = 1;
      1: if (d == 1) begin
           m.st = 2; m.lk = 1; m.idx = 2; m.seen = 0; m.cnt = 0;
         end else m.st = 0;
      default: begin
        if (d == fib(m.idx)) begin
          m.cnt = (m.cnt < mx) ? m.cnt + 1 : mx;
          if (m.idx == L - 1) begin
            m.wp = 1;
            if (m.seen != 0) begin m.pv = 1; m.plen = m.cnt; end
            m.cnt = 0; m.seen = 1; m.idx = 0;
          end else m.idx++;
        end else begin
          m.ep = 1; m.err = (m.err < mx) ? m.err + 1 : mx;
          m.lk = 0; m.st = 0; m.seen = 0;
        end
      end
    endcase
  endfunction

  function automatic int next_ok(input mdl_t m);
    return (m.st == 2) ? fib(m.idx) : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string nm, input mdl_t m, input logic lk,
                     input logic ep, input logic [7:0] ec, input logic wp,
                     input logic [7:0] pl, input logic pv);
    chk({nm, "_locked"}, {31'd0, lk}, m.lk);
    chk({nm, "_err_pulse"}, {31'd0, ep}, m.ep);
    chk({nm, "_err_count"}, {24'd0, ec}, m.err);
    chk({nm, "_wrap_pulse"}, {31'd0, wp}, m.wp);
    chk({nm, "_period_len"}, {24'd0, pl}, m.plen);
    chk({nm, "_period_valid"}, {31'd0, pv}, m.pv);
  endtask

  task automatic check_all();
    cmp("a", ma, lka, epa, eca, wpa, pla, pva);
    cmp("b", mb, lkb, epb, {6'd0, ecb}, wpb, {6'd0, plb}, pvb);
    cmp("c", mc, lkc, epc, ecc, wpc, plc, pvc);
  endtask

  task automatic step(input bit a_v, input int a_d, input bit b_v,
                      input int b_d, input bit c_v, input int c_d);
    @(negedge clk);
    va = a_v; da = a_d[3:0];
    vb = b_v; db = b_d[3:0];
    vc = c_v; dc = c_d[4:0];
    @(posedge clk);
    #1;
    mstep(ma, a_v, a_d, 4, 8);
    mstep(mb, b_v, b_d, 4, 2);
    mstep(mc, c_v, c_d, 5, 8);
    check_all();
  endtask

  function automatic int gen4(input int g);
    return (g == 0) ? 0 : fib((g - 1) % 7);
  endfunction

  int g4;
  int exp_ec[5] = '{1, 2, 3, 3, 3};
  int found;

  initial begin
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};

    // Reset state, checked before any clock edge
    #1 reset = 1'b1;
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Nominal streams: W=4 from a generator starting at 0, W=5 from 1,1
    g4 = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, gen4(g4), 1'b0, $urandom_range(0, 15), 1'b1, fib(i % 8));
      g4++;
    end
    chk("t1_period_len", {24'd0, pla}, 7);
    chk("t6_period_len", {24'd0, plc}, 8);
    chk("t1_err_count", {24'd0, eca}, 0);

    // Valid gaps with junk data mid-stream
    for (int i = 0; i < 3; i++)
      step(1'b0, $urandom_range(0, 15), 1'b0, $urandom_range(0, 15),
           1'b0, $urandom_range(0, 31));
    for (int i = 0; i < 10; i++) begin
      step(1'b1, gen4(g4), 1'b0, 0, 1'b0, 0);
      g4++;
    end
    chk("t3_err_count", {24'd0, eca}, 0);
    chk("t3_locked", {31'd0, lka}, 1);

    // Corrupt a 5 into a 6 while locked, then keep the generator running
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (ma.st == 2 && fib(ma.idx) == 5) begin
        step(1'b1, 6, 1'b0, 0, 1'b0, 0);
        found = 1;
      end else step(1'b1, gen4(g4), 1'b0, 0, 1'b0, 0);
      g4++;
    end
    chk("t2_found", found, 1);
    chk("t2_err_count", {24'd0, eca}, 1);
    chk("t2_unlocked", {31'd0, lka}, 0);
    for (int i = 0; i < 30; i++) begin
      step(1'b1, gen4(g4), 1'b0, 0, 1'b0, 0);
      g4++;
    end
    chk("t2_relocked", {31'd0, lka}, 1);

    // Narrow error counter: five mismatches with relock between them
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 0, 1'b1, 1, 1'b0, 0);
      step(1'b0, 0, 1'b1, 1, 1'b0, 0);
      step(1'b0, 0, 1'b1, 2, 1'b0, 0);
      step(1'b0, 0, 1'b1, 9, 1'b0, 0);
      chk("t4_err_count", {30'd0, ecb}, exp_ec[k]);
    end

    // Randomised phase: mostly-correct streams with injected faults and gaps
    for (int i = 0; i < 300; i++) begin
      int xa, xb, xc;
      xa = ($urandom_range(0, 7) != 0) ? next_ok(ma) : $urandom_range(0, 15);
      xb = ($urandom_range(0, 7) != 0) ? next_ok(mb) : $urandom_range(0, 15);
      xc = ($urandom_range(0, 7) != 0) ? next_ok(mc) : $urandom_range(0, 31);
      step($urandom_range(0, 4) != 0, xa, $urandom_range(0, 4) != 0, xb,
           $urandom_range(0, 4) != 0, xc);
    end

    // Asynchronous reset while locked, then restart the stream
    g4 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, gen4(g4), 1'b0, 0, 1'b0, 0);
      g4++;
    end
    chk("t5_locked_before", {31'd0, lka}, 1);
    #2;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    reset = 1'b1;
    #1;
    ma = '{default: 0}; mb = '{default: 0}; mc = '{default: 0};
    check_all();
    @(negedge clk);
    reset = 1'b0;
    g4 = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, gen4(g4), 1'b0, 0, 1'b0, 0);
      g4++;
    end
    chk("t5_relocked", {31'd0, lka}, 1);
    chk("t5_period_len", {24'd0, pla}, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
